// File: rtl/apb_master_pkg.sv
// ============================================================================
// Module  : apb_master_pkg
// Brief   : Shared types and widths for the APB master bridge.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef APB_SRAM_SIZE
`define APB_SRAM_SIZE 32'h0000_1000
`endif

`default_nettype none

package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  // rdata is sized by the global data width; bridge instances use the same width
  typedef struct packed {
    logic [`DATA_WIDTH-1:0] rdata;
    logic                   err;
    logic                   timeout;
  } apb_rsp_t;

  localparam int TIMEOUT_CYCLES_DFLT = 16;
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES_DFLT + 1);

  function automatic int wait_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module  : apb_wait_timer
// Brief   : Saturating wait-state counter; expired flags the terminal count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
  parameter int MAX_COUNT = 15,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module  : apb_master_bridge
// Brief   : Single-command valid/ready to APB requester with wait-state timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int c_wait_w = wait_width(TIMEOUT_CYCLES);

  apb_mst_state_e        r_state;
  apb_mst_state_e        w_state_nxt;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmo;
  logic                  w_expired;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  apb_rsp_t              r_rsp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        // pready has priority: a late ready on the last allowed cycle still completes
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  apb_wait_timer #(
    .MAX_COUNT (TIMEOUT_CYCLES - 1),
    .CNT_W     (c_wait_w)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_accept),
    .en      ((r_state == ACCESS) && !pready),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_write ? cmd_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= '0;
    end else if (w_done) begin
      r_rsp.rdata   <= r_pwrite ? '0 : prdata;
      r_rsp.err     <= pslverr;
      r_rsp.timeout <= 1'b0;
    end else if (w_tmo) begin
      r_rsp.rdata   <= '0;
      r_rsp.err     <= 1'b1;
      r_rsp.timeout <= 1'b1;
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign psel        = (r_state == SETUP) || (r_state == ACCESS);
  assign penable     = (r_state == ACCESS);
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_rdata   = r_rsp.rdata;
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// Module  : tb_apb_master_bridge
// Brief   : Directed self-checking bench for apb_master_bridge.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef APB_SRAM_SIZE
`define APB_SRAM_SIZE 32'h0000_1000
`endif

`default_nettype none

module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // reset values
    step(); step();
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // T1: zero-wait write 0x10 <- DEADBEEF
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
    pready = 1'b1; prdata = 32'h5555AAAA;
    step();
    cmd_valid = 1'b0;
    chk("t1_setup_psel", {31'd0, psel}, 32'd1);
    chk("t1_setup_penable", {31'd0, penable}, 32'd0);
    chk("t1_setup_pwrite", {31'd0, pwrite}, 32'd1);
    chk("t1_setup_paddr", paddr, 32'h10);
    chk("t1_setup_pwdata", pwdata, 32'hDEADBEEF);
    chk("t1_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("t1_access_penable", {31'd0, penable}, 32'd1);
    chk("t1_access_pwdata", pwdata, 32'hDEADBEEF);
    chk("t1_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("t1_rsp_rdata", rsp_rdata, 32'd0);
    chk("t1_rsp_psel", {31'd0, psel}, 32'd0);
    step();
    chk("t1_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t1_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_idle_paddr_held", paddr, 32'h10);

    // T2: read 0x10, three wait states; pslverr asserted while not ready is ignored
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'hFFFF_FFFF;
    pready = 1'b0; pslverr = 1'b1; prdata = 32'h0;
    step();
    cmd_valid = 1'b0;
    chk("t2_setup_pwrite", {31'd0, pwrite}, 32'd0);
    chk("t2_setup_pwdata_zero", pwdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_access%0d_penable", i), {31'd0, penable}, 32'd1);
      chk($sformatf("t2_access%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
      if (i == 3) begin
        pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEADBEEF;
      end
    end
    step();
    chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t2_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("t2_rsp_penable", {31'd0, penable}, 32'd0);
    step();

    // T3: write beyond SRAM size, slave answers with pslverr
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = `APB_SRAM_SIZE + 32'd4; cmd_wdata = 32'h1234;
    pready = 1'b1; pslverr = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t3_setup_paddr", paddr, 32'h0000_1004);
    step();
    chk("t3_access_psel", {31'd0, psel}, 32'd1);
    step();
    pslverr = 1'b0;
    chk("t3_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("t3_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("t3_rsp_psel", {31'd0, psel}, 32'd0);
    step();

    // T4: slave never ready -> timeout after 16 ACCESS cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    pready = 1'b0; prdata = 32'hCAFEF00D;
    step();
    cmd_valid = 1'b0;
    n = 0;
    for (int g = 0; g < 40; g++) begin
      step();
      if (!penable) break;
      n++;
    end
    chk("t4_access_cycles", n, 32'd16);
    chk("t4_psel", {31'd0, psel}, 32'd0);
    chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("t4_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk("t4_rsp_rdata", rsp_rdata, 32'd0);
    step();

    // T5: response back-pressure with a command waiting
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h0BADF00D;
    pready = 1'b1; rsp_ready = 1'b0;
    step();
    cmd_write = 1'b0; cmd_addr = 32'h40;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("t5_hold%0d_cmd_ready", i), {31'd0, cmd_ready}, 32'd0);
      chk($sformatf("t5_hold%0d_rsp_err", i), {31'd0, rsp_err}, 32'd0);
      chk($sformatf("t5_hold%0d_psel", i), {31'd0, psel}, 32'd0);
      step();
    end
    chk("t5_hold_end_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    prdata = 32'h0000_0077;
    step();
    chk("t5_after_hs_psel", {31'd0, psel}, 32'd0);
    chk("t5_after_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("t5_next_setup_psel", {31'd0, psel}, 32'd1);
    chk("t5_next_setup_penable", {31'd0, penable}, 32'd0);
    chk("t5_next_setup_paddr", paddr, 32'h40);
    step();
    step();
    chk("t5_next_rsp_rdata", rsp_rdata, 32'h0000_0077);
    step();

    // T6: reset asserted during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("t6_pre_penable", {31'd0, penable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_psel", {31'd0, psel}, 32'd0);
    chk("t6_async_penable", {31'd0, penable}, 32'd0);
    chk("t6_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("t6_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t6_rel_paddr", paddr, 32'd0);
    step();
    chk("t6_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    pready = 1'b1; prdata = 32'hDEADBEEF;
    step();
    cmd_valid = 1'b0;
    chk("t6_fresh_setup_psel", {31'd0, psel}, 32'd1);
    step();
    step();
    chk("t6_fresh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t6_fresh_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t6_fresh_rsp_err", {31'd0, rsp_err}, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester for the APB SRAM subsystem. It accepts single read/write commands on a valid/ready command port and runs one APB transfer per command: SETUP, then ACCESS with wait states. It returns read data and error status on a valid/ready response port. It is the only driver of the `apb_inf` signals psel/penable/pwrite/paddr/pwdata, and it samples prdata/pready/pslverr.

## Interface
Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH (32): APB and command address width.
- DATA_WIDTH, default `DATA_WIDTH (32): APB and command data width.
- TIMEOUT_CYCLES, default 16: maximum ACCESS cycles without pready before the transfer is aborted. Legal range is 2..255.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst_n, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: bridge can accept a command.
- cmd_write, in, 1: 1 = write, 0 = read.
- cmd_addr, in, ADDR_WIDTH: byte address.
- cmd_wdata, in, DATA_WIDTH: write data.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_rdata, out, DATA_WIDTH: read data; 0 for writes and for timeouts.
- rsp_err, out, 1: pslverr was sampled, or a timeout occurred.
- rsp_timeout, out, 1: the transfer was aborted by timeout.
- psel, penable, pwrite, out, 1 each: APB controls.
- paddr, out, ADDR_WIDTH; pwdata, out, DATA_WIDTH: APB address and write data.
- prdata, in, DATA_WIDTH; pready, in, 1; pslverr, in, 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_valid && cmd_ready latches write/addr/wdata and moves to SETUP. On reads the wdata register is loaded with 0.
- SETUP:
  - psel=1, penable=0; paddr/pwrite/pwdata come from the latched command.
  - Always moves to ACCESS after one cycle.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata are held unchanged from SETUP.
  - On pready=1:
    - Capture rdata (prdata on a read, 0 on a write), err=pslverr, timeout=0.
    - Move to RESP.
  - On pready=0:
    - Increment wait_cnt.
    - When wait_cnt reaches TIMEOUT_CYCLES-1 with pready still 0: capture rdata=0, err=1, timeout=1, and move to RESP.
- RESP:
  - psel=0, penable=0, rsp_valid=1, response fields stable.
  - rsp_ready moves to IDLE.
- cmd_ready is 1 only in IDLE. This enforces at least two cycles of psel=0 between transfers, because the mandated psel deassert follows every pready.
- The bridge does not range-check addresses. Addresses >= `APB_SRAM_SIZE are issued normally, and the slave's pslverr is forwarded as rsp_err.
- pslverr is ignored unless pready=1 in ACCESS.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, wait_cnt=0.
  - psel=penable=pwrite=0; paddr=0, pwdata=0.
  - rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0.
  - cmd_ready=1 in the first cycle after release.
- Reset mid-transfer:
  - psel/penable drop immediately.
  - Any pending command or response is discarded; no response is emitted.
- Zero-wait transfer, with the command accepted at edge T:
  - SETUP in cycle T+1.
  - ACCESS with pready in cycle T+2.
  - rsp_valid in cycle T+3.
  - If rsp_ready=1 at T+3, cmd_ready=1 at T+4.
- Latency from acceptance to rsp_valid is 3 + N cycles, where N is the number of ACCESS cycles with pready=0.
- All outputs are registered or decoded from state only. No input-to-output combinational paths.
- wait_cnt clears on entry to SETUP.
- paddr/pwdata/pwrite keep their last values in IDLE and RESP.

## Structure
- Package apb_master_pkg holds:
  - enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}.
  - struct apb_rsp_t {rdata, err, timeout}.
  - Localparam WAIT_W = $clog2(TIMEOUT_CYCLES+1).
- Sub-module apb_wait_timer: a saturating wait counter with clear/enable inputs and an expired output, instantiated once.
- The top module contains the FSM, the command/response registers, and the APB output registers.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF with a zero-wait slave:
  - psel at T+1, penable at T+2.
  - pwdata = 0xDEADBEEF is stable across both cycles.
  - rsp_valid at T+3 with err=0, rdata=0.
- Read 0x10 with pready delayed 3 cycles:
  - penable is held high for 4 cycles.
  - rsp_rdata = 0xDEADBEEF, rsp_valid at T+6.
- Write to an address >= `APB_SRAM_SIZE, with the slave returning pslverr=1:
  - rsp_err=1, rsp_timeout=0.
  - psel falls the cycle after pready.
- Hold pready=0 forever, with TIMEOUT_CYCLES=16:
  - After 16 ACCESS cycles psel/penable drop.
  - Response: err=1, timeout=1, rdata=0.
- Hold rsp_ready=0 for 5 cycles with cmd_valid asserted:
  - cmd_ready stays 0 and the response stays stable.
  - The next transfer's SETUP starts 2 cycles after the rsp handshake.
- Assert rst_n low during ACCESS:
  - psel, penable and rsp_valid go to 0 asynchronously.
  - After release, a fresh read completes normally.
